// File: rtl/adrv9001_pkg.sv
// Shared encodings for the ADRV9001 transmit burst controller: channel data
// sources and the burst FSM states.
package adrv9001_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        SRC_AXIS  = 3'd0,
        SRC_ZEROS = 3'd1,
        SRC_ONES  = 3'd2,
        SRC_RAMP  = 3'd3,
        SRC_PN15  = 3'd4,
        SRC_FIXED = 3'd5
    } data_src_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_BURST  = 2'd2,
        ST_GUARD  = 2'd3
    } state_e;

endpackage

// File: rtl/adrv9001_cycle_timer.sv
// Loadable down-counter; expired_o flags the last cycle of a loaded interval,
// so a load of N keeps the caller in its state for exactly N cycles.
module adrv9001_cycle_timer
    import adrv9001_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    output logic               expired_o
);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - TIMER_W'(1);
        end
    end

    assign expired_o = (count_q == TIMER_W'(1));

endmodule

// File: rtl/adrv9001_tx_burst_ctrl.sv
// Transmit burst sequencer: warm-up zeros, burst data, guard zeros around each
// request. Define ADRV9001_TX_UNDERFLOW_CNT_EN to add the underflow_cnt output.
module adrv9001_tx_burst_ctrl
    import adrv9001_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 16,
    parameter int unsigned GUARD_CYCLES  = 8,
    parameter int          LEN_W         = 16
) (
    input  logic             s_axis_aclk,
    input  logic             s_axis_aresetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    input  logic [2:0]       req_src,
    input  logic [31:0]      req_pattern,
    input  logic             abort,
    output logic             tx_enable,
    output logic [2:0]       tx_data_src,
    output logic [31:0]      tx_fixed_pattern,
    input  logic             tx_tready,
    input  logic             user_tvalid,
    output logic             busy,
    output logic             done,
    output logic             aborted,
`ifdef ADRV9001_TX_UNDERFLOW_CNT_EN
    output logic [LEN_W-1:0] underflow_cnt,
`endif
    output logic [LEN_W-1:0] samples_sent
);

    state_e             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [2:0]         src_q;
    logic [31:0]        pattern_q;
    logic [LEN_W-1:0]   samples_q;
    logic               req_ready_q;
    logic               tx_enable_q;
    logic [2:0]         tx_data_src_q;
    logic [31:0]        tx_fixed_pattern_q;
    logic               busy_q;
    logic               done_q;
    logic               aborted_q;

    logic               accept;
    logic               sample;
    logic               final_sample;
    logic               abort_hit;
    logic               enter_guard;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_expired;

    always_comb begin
        accept       = req_valid && req_ready_q && (state_q == ST_IDLE);
        sample       = (state_q == ST_BURST) && tx_tready;
        final_sample = sample &&
                       (((LEN_W+1)'(samples_q) + (LEN_W+1)'(1)) == (LEN_W+1)'(len_q));
        // The last sample wins over a coincident abort: the burst completed normally.
        abort_hit    = abort && ((state_q == ST_WARMUP) ||
                                 ((state_q == ST_BURST) && !final_sample));
        enter_guard  = final_sample || abort_hit;
        timer_load   = (accept && (req_len != '0)) || enter_guard;
        timer_val    = accept ? TIMER_W'(WARMUP_CYCLES) : TIMER_W'(GUARD_CYCLES);
    end

    adrv9001_cycle_timer u_timer (
        .clk_i      (s_axis_aclk),
        .rst_ni     (s_axis_aresetn),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .expired_o  (timer_expired)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q            <= ST_IDLE;
            len_q              <= '0;
            src_q              <= SRC_ZEROS;
            pattern_q          <= '0;
            samples_q          <= '0;
            req_ready_q        <= 1'b0;
            tx_enable_q        <= 1'b0;
            tx_data_src_q      <= SRC_ZEROS;
            tx_fixed_pattern_q <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            aborted_q          <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    req_ready_q   <= 1'b1;
                    tx_enable_q   <= 1'b0;
                    tx_data_src_q <= SRC_ZEROS;
                    busy_q        <= 1'b0;
                    if (accept) begin
                        len_q     <= req_len;
                        src_q     <= req_src;
                        pattern_q <= req_pattern;
                        samples_q <= '0;
                        aborted_q <= 1'b0;
                        if (req_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= ST_WARMUP;
                            req_ready_q <= 1'b0;
                            tx_enable_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                ST_WARMUP: begin
                    if (abort_hit) begin
                        state_q   <= ST_GUARD;
                        aborted_q <= 1'b1;
                    end else if (timer_expired) begin
                        state_q            <= ST_BURST;
                        tx_data_src_q      <= src_q;
                        tx_fixed_pattern_q <= pattern_q;
                    end
                end
                ST_BURST: begin
                    if (sample && (samples_q != '1)) begin
                        samples_q <= samples_q + LEN_W'(1);
                    end
                    if (enter_guard) begin
                        state_q       <= ST_GUARD;
                        tx_data_src_q <= SRC_ZEROS;
                        aborted_q     <= abort_hit;
                    end
                end
                ST_GUARD: begin
                    if (timer_expired) begin
                        state_q     <= ST_IDLE;
                        tx_enable_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef ADRV9001_TX_UNDERFLOW_CNT_EN
    logic [LEN_W-1:0] underflow_q;

    // A consumed AXIS sample with no valid user data is an underflow.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            underflow_q <= '0;
        end else if (accept) begin
            underflow_q <= '0;
        end else if (sample && !user_tvalid && (src_q == SRC_AXIS) && (underflow_q != '1)) begin
            underflow_q <= underflow_q + LEN_W'(1);
        end
    end

    assign underflow_cnt = underflow_q;
`else
    logic unused_user_tvalid;
    assign unused_user_tvalid = user_tvalid;
`endif

    assign req_ready        = req_ready_q;
    assign tx_enable        = tx_enable_q;
    assign tx_data_src      = tx_data_src_q;
    assign tx_fixed_pattern = tx_fixed_pattern_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign aborted          = aborted_q;
    assign samples_sent     = samples_q;

endmodule

// File: tb/tb_adrv9001_tx_burst_ctrl.sv
// Directed and randomized bursts checked cycle by cycle against a phase-based
// reference model of warm-up / burst / guard timing.
module tb_adrv9001_tx_burst_ctrl;

    localparam int W    = 16;
    localparam int G    = 8;
    localparam int LW   = 16;
    localparam int MAXC = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [LW-1:0] req_len = '0;
    logic [2:0]    req_src = 3'd0;
    logic [31:0]   req_pattern = '0;
    logic          abort = 1'b0;
    logic          tx_enable;
    logic [2:0]    tx_data_src;
    logic [31:0]   tx_fixed_pattern;
    logic          tx_tready = 1'b0;
    logic          user_tvalid = 1'b1;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] samples_sent;
`ifdef ADRV9001_TX_UNDERFLOW_CNT_EN
    logic [LW-1:0] underflow_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adrv9001_tx_burst_ctrl #(
        .WARMUP_CYCLES (W),
        .GUARD_CYCLES  (G),
        .LEN_W         (LW)
    ) dut (
        .s_axis_aclk      (clk),
        .s_axis_aresetn   (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_len          (req_len),
        .req_src          (req_src),
        .req_pattern      (req_pattern),
        .abort            (abort),
        .tx_enable        (tx_enable),
        .tx_data_src      (tx_data_src),
        .tx_fixed_pattern (tx_fixed_pattern),
        .tx_tready        (tx_tready),
        .user_tvalid      (user_tvalid),
        .busy             (busy),
        .done             (done),
        .aborted          (aborted),
`ifdef ADRV9001_TX_UNDERFLOW_CNT_EN
        .underflow_cnt    (underflow_cnt),
`endif
        .samples_sent     (samples_sent)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // tr_mode: 0 toggling tready, 1 random 75%, 2 always high.
    // uv_mode: 0 user_tvalid high, 1 random, 2 low for the first three burst cycles.
    task automatic run_burst(input int len, input int src, input logic [31:0] pat,
                             input int abort_at, input int tr_mode, input int uv_mode,
                             input bit abort_with_req, input string name);
        bit tr_a [0:MAXC-1];
        bit uv_a [0:MAXC-1];
        int n, und, end_main, done_c, exp_src;
        bit ab, found;

        for (int c = 0; c < MAXC; c++) begin
            case (tr_mode)
                0:       tr_a[c] = c[0];
                1:       tr_a[c] = ($urandom_range(0, 3) != 0);
                default: tr_a[c] = 1'b1;
            endcase
            case (uv_mode)
                0:       uv_a[c] = 1'b1;
                1:       uv_a[c] = ($urandom_range(0, 2) != 0);
                default: uv_a[c] = !(c > W && c <= W + 3);
            endcase
        end

        // Reference model: walk the warm-up then burst cycles until completion or abort.
        n = 0; und = 0; ab = 1'b0; end_main = 0; found = 1'b0;
        for (int c = 1; c < MAXC - G - 2 && !found; c++) begin
            if (c <= W) begin
                if (c == abort_at) begin ab = 1'b1; end_main = c; found = 1'b1; end
            end else begin
                if (tr_a[c]) begin
                    n++;
                    if (src == 0 && !uv_a[c]) und++;
                end
                if (tr_a[c] && n == len) begin
                    end_main = c; found = 1'b1;
                end else if (c == abort_at) begin
                    ab = 1'b1; end_main = c; found = 1'b1;
                end
            end
        end
        if (!found) begin
            errors++;
            $display("FAIL %s: reference model ran out of cycle budget", name);
            return;
        end
        done_c = end_main + G + 1;

        @(negedge clk);
        req_valid   = 1'b1;
        req_len     = LW'(len);
        req_src     = 3'(src);
        req_pattern = pat;
        abort       = abort_with_req;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= done_c; c++) begin
            if (c > 1) @(negedge clk);
            exp_src = (c > W && c <= end_main) ? src : 1;
            if (c < done_c) begin
                chk({name, "_en"}, 64'(tx_enable), 64'd1);
                chk({name, "_src"}, 64'(tx_data_src), 64'(exp_src));
                chk({name, "_busy"}, 64'(busy), 64'd1);
                chk({name, "_done_lo"}, 64'(done), 64'd0);
                if (c > W && c <= end_main)
                    chk({name, "_pat"}, 64'(tx_fixed_pattern), 64'(pat));
            end else begin
                chk({name, "_en_fall"}, 64'(tx_enable), 64'd0);
                chk({name, "_done"}, 64'(done), 64'd1);
                chk({name, "_aborted"}, 64'(aborted), 64'(ab));
                chk({name, "_samples"}, 64'(samples_sent), 64'(n));
                chk({name, "_busy_end"}, 64'(busy), 64'd0);
                chk({name, "_ready_end"}, 64'(req_ready), 64'd1);
`ifdef ADRV9001_TX_UNDERFLOW_CNT_EN
                chk({name, "_underflow"}, 64'(underflow_cnt), 64'(und));
`endif
            end
            tx_tready   = tr_a[c];
            user_tvalid = uv_a[c];
            abort       = (c == abort_at);
        end
        @(negedge clk);
        tx_tready = 1'b0; user_tvalid = 1'b1; abort = 1'b0;
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
        $display("burst %s len=%0d src=%0d abort_at=%0d -> samples=%0d aborted=%0d done_cycle=%0d",
                 name, len, src, abort_at, n, ab, done_c);
    endtask

    initial begin
        int len, src, ab_at;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_en", 64'(tx_enable), 64'd0);
        chk("rst_src", 64'(tx_data_src), 64'd1);
        chk("rst_pat", 64'(tx_fixed_pattern), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_aborted", 64'(aborted), 64'd0);
        chk("rst_samples", 64'(samples_sent), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        $display("reset: req_ready=%0d tx_enable=%0d", req_ready, tx_enable);

        // Nominal burst with toggling tready
        run_burst(4, 3, 32'h0, -1, 0, 0, 1'b0, "nominal");

        // Zero-length request
        @(negedge clk);
        req_valid = 1'b1; req_len = '0; req_src = 3'd2;
        @(negedge clk);
        req_valid = 1'b0;
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_en", 64'(tx_enable), 64'd0);
        chk("len0_busy", 64'(busy), 64'd0);
        chk("len0_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("len0_done_pulse", 64'(done), 64'd0);
        chk("len0_en2", 64'(tx_enable), 64'd0);
        $display("len0: done pulse and no enable");

        // Abort after ten samples, abort during warm-up, abort alongside request
        run_burst(100, 5, 32'hA5A5_1234, W + 10, 2, 0, 1'b0, "abort10");
        run_burst(20, 2, 32'h0, 5, 2, 0, 1'b0, "abort_warm");
        run_burst(6, 4, 32'h0, -1, 2, 0, 1'b1, "abort_idle");
        // Abort on the final sample completes normally
        run_burst(5, 1, 32'h0, W + 5, 2, 0, 1'b0, "abort_final");
        // AXIS source with three underflow cycles
        run_burst(8, 0, 32'h0, -1, 2, 2, 1'b0, "underflow");

        // Randomized bursts
        for (int i = 0; i < 12; i++) begin
            len   = $urandom_range(1, 40);
            src   = $urandom_range(0, 5);
            ab_at = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, W + len + 4);
            run_burst(len, src, $urandom, ab_at, $urandom_range(0, 2), 1, $urandom_range(0, 1) == 1,
                      $sformatf("rand%0d", i));
        end

        // Reset in the middle of a burst
        @(negedge clk);
        req_valid = 1'b1; req_len = LW'(30); req_src = 3'd3;
        @(negedge clk);
        req_valid = 1'b0; tx_tready = 1'b1;
        repeat (W + 3) @(negedge clk);
        chk("mid_src_pre", 64'(tx_data_src), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 64'(tx_enable), 64'd0);
        chk("mid_rst_src", 64'(tx_data_src), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        tx_tready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_en2", 64'(tx_enable), 64'd0);
        $display("midburst reset: tx_enable dropped, req_ready=%0d", req_ready);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
